// File: rtl/ecc_pkg.sv
// Shared constants, types and write-list helpers for the ECC APB sequencer.
package ecc_pkg;

    // Register map of the ECC encoder/decoder slave.
    localparam logic [7:0] CTRL_ADDR           = 8'd0;
    localparam logic [7:0] DATA_ADDR           = 8'd4;
    localparam logic [7:0] CODEWORD_WIDTH_ADDR = 8'd8;
    localparam logic [7:0] NOISE_ADDR          = 8'd12;

    typedef enum logic [1:0] {
        OP_ENCODE       = 2'd0,
        OP_DECODE       = 2'd1,
        OP_FULL_CHANNEL = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2
    } width_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } seq_state_e;

    // Which register of the write list is being (or will next be) written.
    typedef enum logic [1:0] {
        WR_CW    = 2'd0,
        WR_NOISE = 2'd1,
        WR_DATA  = 2'd2,
        WR_CTRL  = 2'd3
    } wr_sel_e;

    // A job is rejected when its op or width code falls outside the defined encodings.
    function automatic logic job_is_illegal(input logic [1:0] op, input logic [1:0] width);
        logic op_ok;
        logic width_ok;
        op_ok    = (op == OP_ENCODE) || (op == OP_DECODE) || (op == OP_FULL_CHANNEL);
        width_ok = (width == W8) || (width == W16) || (width == W32);
        return !(op_ok && width_ok);
    endfunction

    // First register of the list: width is skipped when the slave already holds it.
    function automatic wr_sel_e first_write(input logic [1:0] op, input logic [1:0] width,
                                            input logic cache_valid, input logic [1:0] cache_width);
        wr_sel_e sel;
        if (!cache_valid || (width != cache_width)) begin
            sel = WR_CW;
        end else if (op == OP_FULL_CHANNEL) begin
            sel = WR_NOISE;
        end else begin
            sel = WR_DATA;
        end
        return sel;
    endfunction

    // Successor in the write list; CTRL is always last.
    function automatic wr_sel_e next_write(input wr_sel_e cur, input logic [1:0] op);
        wr_sel_e sel;
        case (cur)
            WR_CW:    sel = (op == OP_FULL_CHANNEL) ? WR_NOISE : WR_DATA;
            WR_NOISE: sel = WR_DATA;
            WR_DATA:  sel = WR_CTRL;
            WR_CTRL:  sel = WR_CTRL;
            default:  sel = WR_CTRL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apb_write_engine.sv
// Single APB write transfer: SETUP then ACCESS, restartable on the ACCESS cycle
// so consecutive transfers run back-to-back.
module apb_write_engine #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [AMBA_ADDR_WIDTH-1:0] addr,
    input  logic [AMBA_WORD-1:0]       wdata,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata,
    output logic                       done
);

    logic                       psel_r;
    logic                       penable_r;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_r;
    logic [AMBA_WORD-1:0]       pwdata_r;

    // APB phase sequencing; address and data are held from SETUP through ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
        end else if (start) begin
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            paddr_r   <= addr;
            pwdata_r  <= wdata;
        end else if (psel_r && !penable_r) begin
            penable_r <= 1'b1;
        end else begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end
    end

    assign psel    = psel_r;
    assign penable = penable_r;
    assign pwrite  = psel_r;
    assign paddr   = paddr_r;
    assign pwdata  = pwdata_r;
    assign done    = psel_r & penable_r;

endmodule

// File: rtl/ecc_apb_sequencer.sv
// Job-driven APB master for the ECC encoder/decoder slave: writes the job's
// registers, waits for operation_done (with timeout) and returns the result.
module ecc_apb_sequencer
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_op,
    input  logic [1:0]                 job_width,
    input  logic [DATA_WIDTH-1:0]      job_data,
    input  logic [DATA_WIDTH-1:0]      job_noise,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_num_err,
    output logic                       res_timeout,
    output logic                       res_illegal,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_num_err,
    output logic                       busy
);

    localparam int                CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    seq_state_e                 state_r, state_next;
    wr_sel_e                    wr_sel_r, wr_sel_next;
    logic                       start_s;
    logic                       eng_done_s;
    logic [AMBA_ADDR_WIDTH-1:0] wr_addr_s;
    logic [AMBA_WORD-1:0]       wr_data_s;

    logic [1:0]                 op_r, width_r;
    logic [DATA_WIDTH-1:0]      data_r, noise_r;
    logic [1:0]                 src_op_s, src_width_s;
    logic [DATA_WIDTH-1:0]      src_data_s, src_noise_s;

    logic                       cache_valid_r;
    logic [1:0]                 cache_width_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       accept_s;
    logic                       illegal_s;
    logic                       expire_s;

    logic                       job_ready_r, busy_r, res_valid_r;
    logic                       res_timeout_r, res_illegal_r;
    logic [DATA_WIDTH-1:0]      res_data_r;
    logic [1:0]                 res_num_err_r;

    assign accept_s  = job_valid && (state_r == ST_IDLE);
    assign illegal_s = job_is_illegal(job_op, job_width);
    assign expire_s  = (cnt_r == CNT_MAX);

    // Job fields come straight from the port on the accept cycle, from the job registers afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            src_op_s    = job_op;
            src_width_s = job_width;
            src_data_s  = job_data;
            src_noise_s = job_noise;
        end else begin
            src_op_s    = op_r;
            src_width_s = width_r;
            src_data_s  = data_r;
            src_noise_s = noise_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            wr_sel_r <= WR_CW;
        end else begin
            state_r  <= state_next;
            wr_sel_r <= wr_sel_next;
        end
    end

    // Next-state logic and launch of each register write.
    always_comb begin
        state_next  = state_r;
        wr_sel_next = wr_sel_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (job_valid && illegal_s) begin
                    state_next = ST_RESP;
                end else if (job_valid) begin
                    state_next  = ST_SETUP;
                    wr_sel_next = first_write(job_op, job_width, cache_valid_r, cache_width_r);
                    start_s     = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (wr_sel_r == WR_CTRL) begin
                    state_next = ST_WAIT;
                end else begin
                    state_next  = ST_SETUP;
                    wr_sel_next = next_write(wr_sel_r, op_r);
                    start_s     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (core_done || expire_s) begin
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_RESP;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address and zero-extended data for the register about to be written.
    always_comb begin
        case (wr_sel_next)
            WR_CW: begin
                wr_addr_s = AMBA_ADDR_WIDTH'(CODEWORD_WIDTH_ADDR);
                wr_data_s = AMBA_WORD'(src_width_s);
            end
            WR_NOISE: begin
                wr_addr_s = AMBA_ADDR_WIDTH'(NOISE_ADDR);
                wr_data_s = AMBA_WORD'(src_noise_s);
            end
            WR_DATA: begin
                wr_addr_s = AMBA_ADDR_WIDTH'(DATA_ADDR);
                wr_data_s = AMBA_WORD'(src_data_s);
            end
            WR_CTRL: begin
                wr_addr_s = AMBA_ADDR_WIDTH'(CTRL_ADDR);
                wr_data_s = AMBA_WORD'(src_op_s);
            end
            default: begin
                wr_addr_s = '0;
                wr_data_s = '0;
            end
        endcase
    end

    apb_write_engine #(
        .AMBA_WORD       (AMBA_WORD),
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
    ) u_apb_write_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .addr    (wr_addr_s),
        .wdata   (wr_data_s),
        .psel    (PSEL),
        .penable (PENABLE),
        .pwrite  (PWRITE),
        .paddr   (PADDR),
        .pwdata  (PWDATA),
        .done    (eng_done_s)
    );

    // Job capture and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= 2'd0;
            width_r     <= 2'd0;
            data_r      <= '0;
            noise_r     <= '0;
            job_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            job_ready_r <= (state_next == ST_IDLE);
            busy_r      <= (state_next != ST_IDLE);
            if (accept_s) begin
                op_r    <= job_op;
                width_r <= job_width;
                data_r  <= job_data;
                noise_r <= job_noise;
            end
        end
    end

    // Width cache: set when the width write completes, dropped on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_r <= 1'b0;
            cache_width_r <= 2'd0;
        end else if (state_r == ST_ACCESS && wr_sel_r == WR_CW && eng_done_s) begin
            cache_valid_r <= 1'b1;
            cache_width_r <= width_r;
        end else if (state_r == ST_WAIT && !core_done && expire_s) begin
            cache_valid_r <= 1'b0;
        end
    end

    // Timeout counter: cleared on WAIT_DONE entry, advances every waiting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r != ST_WAIT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Result registers, held from capture until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r   <= 1'b0;
            res_data_r    <= '0;
            res_num_err_r <= 2'd0;
            res_timeout_r <= 1'b0;
            res_illegal_r <= 1'b0;
        end else if (accept_s && illegal_s) begin
            res_valid_r   <= 1'b1;
            res_data_r    <= '0;
            res_num_err_r <= 2'd0;
            res_timeout_r <= 1'b0;
            res_illegal_r <= 1'b1;
        end else if (state_r == ST_WAIT && core_done) begin
            res_valid_r   <= 1'b1;
            res_data_r    <= core_data_out;
            res_num_err_r <= core_num_err;
            res_timeout_r <= 1'b0;
            res_illegal_r <= 1'b0;
        end else if (state_r == ST_WAIT && expire_s) begin
            res_valid_r   <= 1'b1;
            res_data_r    <= '0;
            res_num_err_r <= 2'd0;
            res_timeout_r <= 1'b1;
            res_illegal_r <= 1'b0;
        end else if (state_r == ST_RESP && res_ready) begin
            res_valid_r   <= 1'b0;
            res_data_r    <= '0;
            res_num_err_r <= 2'd0;
            res_timeout_r <= 1'b0;
            res_illegal_r <= 1'b0;
        end
    end

    assign job_ready   = job_ready_r;
    assign busy        = busy_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_num_err = res_num_err_r;
    assign res_timeout = res_timeout_r;
    assign res_illegal = res_illegal_r;

endmodule
